// File: rtl/gpio_pkg.sv
// Shared types and defaults for the GPIO header read path.
package gpio_pkg;

  localparam int unsigned GPIO_WIDTH       = 8;
  localparam int unsigned GPIO_TURN_CYCLES = 4;

  typedef enum logic [2:0] {
    DRIVE  = 3'd0,
    REL    = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    HOLD   = 3'd4,
    RET    = 3'd5
  } state_t;

endpackage

// File: rtl/gpio_reader_sync.sv
// Two-flop synchroniser for asynchronous pad inputs.
module gpio_reader_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives a settled value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpio_reader.sv
// Owns GPIO header direction: drives by default, on request turns the bus
// around, debounces the synchronised pins and returns one byte.
module gpio_reader
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH           = GPIO_WIDTH,
  parameter int unsigned TURN_CYCLES     = GPIO_TURN_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic             gpio_oe,
  output logic             gpio_rw,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  output logic             rd_busy,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_err,
  output logic             rd_valid,
  input  logic             rd_ready
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] TURN_LAST   = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(TURN_CYCLES + 1);
  localparam logic [CW-1:0] DEB_DONE    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TO_DONE     = CW'(TIMEOUT_CYCLES);

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [CW-1:0]    stable, stable_next;
  logic [WIDTH-1:0] cand, cand_next;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] out_next, data_next;
  logic             err_next;
  logic             oe_next, rw_next, valid_next, busy_next;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  gpio_reader_sync #(.WIDTH(WIDTH)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (gpio_in),
    .q    (sync)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RET;
      cnt      <= '0;
      stable   <= '0;
      cand     <= '0;
      gpio_out <= '0;
      gpio_oe  <= 1'b0;
      gpio_rw  <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
      rd_valid <= 1'b0;
      rd_busy  <= 1'b1;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      stable   <= stable_next;
      cand     <= cand_next;
      gpio_out <= out_next;
      gpio_oe  <= oe_next;
      gpio_rw  <= rw_next;
      rd_data  <= data_next;
      rd_err   <= err_next;
      rd_valid <= valid_next;
      rd_busy  <= busy_next;
    end
  end

  // Next-state, counter/debounce update and output decode of the next state.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    stable_next = stable;
    cand_next   = cand;
    out_next    = gpio_out;
    data_next   = rd_data;
    err_next    = rd_err;

    case (state)
      DRIVE: begin
        if (rd_req) begin
          state_next = REL;
          cnt_next   = '0;
        end
      end
      REL: begin
        if (cnt == TURN_LAST) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end else begin
          cnt_next = sat_inc(cnt);
        end
      end
      SETTLE: begin
        // Turnaround plus two cycles to flush the synchroniser.
        if (cnt == SETTLE_LAST) begin
          state_next  = SAMPLE;
          cnt_next    = CW'(1);
          cand_next   = sync;
          stable_next = CW'(1);
        end else begin
          cnt_next = sat_inc(cnt);
        end
      end
      SAMPLE: begin
        // Debounce is tested first so it wins a tie with the timeout.
        if (stable == DEB_DONE) begin
          state_next = HOLD;
          data_next  = cand;
          err_next   = 1'b0;
        end else if (cnt == TO_DONE) begin
          state_next = HOLD;
          data_next  = sync;
          err_next   = 1'b1;
        end else begin
          cnt_next = sat_inc(cnt);
          if (sync == cand) begin
            stable_next = sat_inc(stable);
          end else begin
            cand_next   = sync;
            stable_next = CW'(1);
          end
        end
      end
      HOLD: begin
        if (rd_ready) begin
          state_next = RET;
          cnt_next   = '0;
        end
      end
      RET: begin
        if (cnt == TURN_LAST) begin
          state_next = DRIVE;
          cnt_next   = '0;
        end else begin
          cnt_next = sat_inc(cnt);
        end
      end
      default: begin
        state_next = RET;
        cnt_next   = '0;
      end
    endcase

    // Output value is refreshed on the edge into DRIVE so it is never stale.
    if (state == DRIVE || state_next == DRIVE) begin
      out_next = wr_data;
    end

    oe_next    = (state_next == DRIVE);
    rw_next    = (state_next == SETTLE) || (state_next == SAMPLE) ||
                 (state_next == HOLD);
    valid_next = (state_next == HOLD);
    busy_next  = (state_next != DRIVE);
  end

endmodule
